// File: rtl/param_counter_pkg.sv
// param_counter_pkg: shared constants and types for the param_counter block.
//   DIR_UP / DIR_DOWN : encodings of the 'up' direction input.
//   NEXT_MAX_W        : widest counter supported by the shared result type.
//   next_t            : next-state result carrier (value plus boundary bit).
//                       Sized for the widest supported counter; users take
//                       the low WIDTH bits of 'value'.
package param_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int NEXT_MAX_W = 32;

    typedef struct packed {
        logic                  boundary;
        logic [NEXT_MAX_W-1:0] value;
    } next_t;

endpackage

// File: rtl/param_counter_next.sv
// param_counter_next: combinational next-count evaluation for param_counter.
// Given the current count, step, limit and direction it returns the value
// the counter moves to on an enabled cycle and whether that move is a
// boundary event.
//   cur      in  WIDTH   current count
//   step     in  STEP_W  step magnitude (zero-extended; 0 = hold)
//   limit    in  WIDTH   terminal value, range is 0..limit
//   up       in  1       DIR_UP / DIR_DOWN
//   value    out WIDTH   next count
//   boundary out 1       boundary event flag
// Build option: PCOUNTER_SAT_EN selects saturate instead of wrap on overflow.
module param_counter_next
    import param_counter_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  cur,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              up,
    output logic [WIDTH-1:0]  value,
    output logic              boundary
);

    logic [WIDTH-1:0] step_ext;
    // One extra bit so cur + step never wraps silently when limit is all-ones.
    logic [WIDTH:0]   sum;

    assign step_ext = WIDTH'(step);
    assign sum      = {1'b0, cur} + {1'b0, step_ext};

    always_comb begin
        value    = cur;
        boundary = 1'b0;
        if (step_ext == '0) begin
            // Zero step holds, even if limit was lowered below cur.
            value    = cur;
            boundary = 1'b0;
        end else if (cur > limit) begin
            // Limit moved below the count: snap to the edge in the direction
            // of travel, independent of wrap/saturate.
            boundary = 1'b1;
            value    = (up == DIR_UP) ? '0 : limit;
        end else if (up == DIR_UP) begin
            if (sum <= {1'b0, limit}) begin
                value = sum[WIDTH-1:0];
            end else begin
                boundary = 1'b1;
`ifdef PCOUNTER_SAT_EN
                value    = limit;
`else
                value    = '0;
`endif
            end
        end else begin
            if (cur >= step_ext) begin
                value = cur - step_ext;
            end else begin
                boundary = 1'b1;
`ifdef PCOUNTER_SAT_EN
                value    = '0;
`else
                value    = limit;
`endif
            end
        end
    end

endmodule

// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with synchronous load,
// programmable step, runtime terminal value, terminal-count pulse and a
// sticky overflow flag.
//   clk     in  1       rising-edge clock
//   reset   in  1       synchronous active-high reset
//   enabled in  1       count one step this cycle
//   load    in  1       load min(in_a, limit)
//   up      in  1       1 = up, 0 = down
//   step    in  STEP_W  step magnitude, 0 = hold
//   limit   in  WIDTH   terminal value (range 0..limit)
//   in_a    in  WIDTH   load value
//   out_a   out WIDTH   registered count
//   tc      out 1       one-cycle pulse per boundary event
//   ovf     out 1       sticky boundary flag, cleared by reset or load
// Build option: PCOUNTER_SAT_EN (defined = saturate, undefined = wrap).
module param_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enabled,
    input  logic              load,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [WIDTH-1:0]  in_a,
    output logic [WIDTH-1:0]  out_a,
    output logic              tc,
    output logic              ovf
);

    logic [WIDTH-1:0] next_value;
    logic             next_boundary;
    logic [WIDTH-1:0] load_value;

    param_counter_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .cur      (out_a),
        .step     (step),
        .limit    (limit),
        .up       (up),
        .value    (next_value),
        .boundary (next_boundary)
    );

    // Loads are clamped into the legal range.
    assign load_value = (in_a > limit) ? limit : in_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_a <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            out_a <= load_value;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (enabled) begin
            out_a <= next_value;
            tc    <= next_boundary;
            ovf   <= ovf | next_boundary;
        end else begin
            tc    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
module tb_param_counter;

    localparam int WIDTH  = 12;
    localparam int STEP_W = 4;

    logic              clk;
    logic              reset;
    logic              enabled;
    logic              load;
    logic              up;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  out_a;
    logic              tc;
    logic              ovf;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] out;
        logic             tc;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    param_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enabled (enabled),
        .load    (load),
        .up      (up),
        .step    (step),
        .limit   (limit),
        .in_a    (in_a),
        .out_a   (out_a),
        .tc      (tc),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Picks the expected value for wrap or saturate builds.
    function automatic logic [WIDTH-1:0] mode(input logic [WIDTH-1:0] wrap_v,
                                              input logic [WIDTH-1:0] sat_v);
`ifdef PCOUNTER_SAT_EN
        return sat_v;
`else
        return wrap_v;
`endif
    endfunction

    function automatic logic mode_b(input logic wrap_v, input logic sat_v);
`ifdef PCOUNTER_SAT_EN
        return sat_v;
`else
        return wrap_v;
`endif
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue its expected result.
    task automatic apply(input string nm,
                         input logic r, input logic ld, input logic en,
                         input logic u, input int st, input int lim, input int a,
                         input logic [WIDTH-1:0] e_out, input logic e_tc,
                         input logic e_ovf);
        exp_t e;
        @(negedge clk);
        reset   = r;
        load    = ld;
        enabled = en;
        up      = u;
        step    = STEP_W'(st);
        limit   = WIDTH'(lim);
        in_a    = WIDTH'(a);
        e.name  = nm;
        e.out   = e_out;
        e.tc    = e_tc;
        e.ovf   = e_ovf;
        sb.push_back(e);
    endtask

    // Monitor: each edge that follows a queued vector yields one output to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (out_a !== e.out || tc !== e.tc || ovf !== e.ovf) begin
                    n_err++;
                    $display("FAIL %s: got out_a=%h tc=%b ovf=%b, expected out_a=%h tc=%b ovf=%b",
                             e.name, out_a, tc, ovf, e.out, e.tc, e.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d vectors pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0; load = 1'b0; enabled = 1'b0; up = 1'b1;
        step = '0; limit = '0; in_a = '0;

        //     name             rst ld en up st  lim     in_a    out                     tc  ovf
        apply("reset_vs_load",   1, 1, 1, 1, 3,  10,     'h123,  12'd0,                  0,  0);
        apply("load_8",          0, 1, 0, 1, 0,  10,     8,      12'd8,                  0,  0);
        apply("up_over_limit",   0, 0, 1, 1, 3,  10,     0,      mode(12'd0, 12'd10),    1,  1);
        apply("idle_hold",       0, 0, 0, 1, 3,  10,     0,      mode(12'd0, 12'd10),    0,  1);
        apply("load_clears_ovf", 0, 1, 0, 1, 0,  10,     2,      12'd2,                  0,  0);
        apply("down_under_0",    0, 0, 1, 0, 3,  10,     0,      mode(12'd10, 12'd0),    1,  1);
        apply("down_again",      0, 0, 1, 0, 3,  10,     0,      mode(12'd7, 12'd0),     mode_b(0, 1), 1);
        apply("load_ffe",        0, 1, 0, 1, 0,  'hFFF,  'hFFE,  12'hFFE,                0,  0);
        apply("up_to_fff",       0, 0, 1, 1, 1,  'hFFF,  0,      12'hFFF,                0,  0);
        apply("up_past_fff",     0, 0, 1, 1, 1,  'hFFF,  0,      mode(12'h000, 12'hFFF), 1,  1);
        apply("up_after_fff",    0, 0, 1, 1, 1,  'hFFF,  0,      mode(12'h001, 12'hFFF), mode_b(0, 1), 1);
        apply("load_and_enable", 0, 1, 1, 1, 3,  40,     50,     12'd40,                 0,  0);
        apply("load_30",         0, 1, 0, 1, 0,  40,     30,     12'd30,                 0,  0);
        apply("lowered_step0",   0, 0, 1, 1, 0,  20,     0,      12'd30,                 0,  0);
        apply("lowered_up",      0, 0, 1, 1, 1,  20,     0,      12'd0,                  1,  1);
        apply("reload_30",       0, 1, 0, 1, 0,  40,     30,     12'd30,                 0,  0);
        apply("lowered_down",    0, 0, 1, 0, 2,  20,     0,      12'd20,                 1,  1);
        apply("b2b_up_over",     0, 0, 1, 1, 5,  20,     0,      mode(12'd0, 12'd20),    1,  1);
        apply("load_lim0",       0, 1, 0, 1, 0,  0,      5,      12'd0,                  0,  0);
        apply("lim0_up",         0, 0, 1, 1, 1,  0,      0,      12'd0,                  1,  1);
        apply("lim0_idle",       0, 0, 0, 1, 1,  0,      0,      12'd0,                  0,  1);
        apply("lim0_down",       0, 0, 1, 0, 15, 0,      0,      12'd0,                  1,  1);
        apply("load_7",          0, 1, 0, 1, 0,  100,    7,      12'd7,                  0,  0);
        apply("count_up_15",     0, 0, 1, 1, 15, 100,    0,      12'd22,                 0,  0);
        apply("count_down_4",    0, 0, 1, 0, 4,  100,    0,      12'd18,                 0,  0);
        apply("reset_mid_count", 1, 0, 1, 1, 5,  100,    0,      12'd0,                  0,  0);

        @(negedge clk);
        reset = 1'b0; load = 1'b0; enabled = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
